// File: rtl/comp2_pkg.sv
// comp2_pkg: shared definitions for the digit-serial two's-complement unit.
//   mode_t      : operation select (PASS, NEG, ABS, NABS)
//   state_t     : sequencing states (IDLE, RUN, DONE)
//   num_digits  : number of D-bit digits in an N-bit operand
//   cnt_width   : digit counter width, clog2(N/D) with a floor of 1
package comp2_pkg;

   typedef enum logic [1:0] {
      MODE_PASS = 2'b00,
      MODE_NEG  = 2'b01,
      MODE_ABS  = 2'b10,
      MODE_NABS = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   function automatic int num_digits(input int n, input int d);
      return n / d;
   endfunction

   function automatic int cnt_width(input int n, input int d);
      int w;
      w = $clog2(n / d);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/comp2_digit.sv
// comp2_digit: one D-bit digit slice of the serial complementer.
//   d         in  D  operand digit
//   carry_in  in  1  carry from the previous (less significant) digit
//   neg       in  1  1: produce ~d + carry_in, 0: pass d through
//   r         out D  result digit
//   carry_out out 1  carry into the next digit (carry_in when neg=0)
module comp2_digit
   import comp2_pkg::*;
#(
   parameter int D = 1
) (
   input  logic [D-1:0] d,
   input  logic         carry_in,
   input  logic         neg,
   output logic [D-1:0] r,
   output logic         carry_out
);

   logic [D:0] sum;

   always_comb begin
      sum       = {1'b0, ~d} + {{D{1'b0}}, carry_in};
      r         = d;
      carry_out = carry_in;
      if (neg) begin
         r         = sum[D-1:0];
         carry_out = sum[D];
      end
   end

endmodule

// File: rtl/comp2_serial.sv
// comp2_serial: digit-serial two's-complement unit (PASS/NEG/ABS/NABS),
// D bits per cycle, least significant digit first.
//   clk   in  1  clock, rising edge
//   rst   in  1  synchronous active-high reset
//   start in  1  launch request, honoured only in IDLE
//   mode  in  2  operation select, latched with A
//   A     in  N  operand, latched on accepted start
//   busy  out 1  high while an operation is in flight
//   done  out 1  one-cycle pulse, C and ovf valid
//   C     out N  result, held until the next operation completes
//   ovf   out 1  most-negative overflow flag, held like C
// Optional build macro COMP2_SAT_EN: on overflow C saturates to the largest
// positive value instead of wrapping back to the most-negative value.
module comp2_serial
   import comp2_pkg::*;
#(
   parameter int N = 8,
   parameter int D = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [1:0]   mode,
   input  logic [N-1:0] A,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] C,
   output logic         ovf
);

   localparam int              NDIG     = num_digits(N, D);
   localparam int              CW       = cnt_width(N, D);
   localparam logic [CW-1:0]   LAST     = CW'(NDIG - 1);
   localparam logic [N-1:0]    MOST_NEG = N'(1) << (N - 1);
   localparam logic [N-1:0]    MAX_POS  = ~MOST_NEG;

   if (N % D != 0) begin : g_bad_digit
      $error("comp2_serial: N must be a multiple of D");
   end

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt;
   logic           carry;
   logic           neg_q;
   logic           ovf_pend;
   logic           neg_sel;
   logic [N-1:0]   opnd;
   logic [N-1:0]   res;
   logic [D-1:0]   r_dig;
   logic           carry_nxt;

   comp2_digit #(.D(D)) u_digit (
      .d         (opnd[D-1:0]),
      .carry_in  (carry),
      .neg       (neg_q),
      .r         (r_dig),
      .carry_out (carry_nxt)
   );

   always_comb begin
      neg_sel = 1'b0;
      case (mode_t'(mode))
         MODE_PASS: neg_sel = 1'b0;
         MODE_NEG:  neg_sel = 1'b1;
         MODE_ABS:  neg_sel = A[N-1];
         MODE_NABS: neg_sel = ~A[N-1];
         default:   neg_sel = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (cnt == LAST) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         carry    <= 1'b1;
         neg_q    <= 1'b0;
         ovf_pend <= 1'b0;
         opnd     <= '0;
         res      <= '0;
         done     <= 1'b0;
         C        <= '0;
         ovf      <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  opnd     <= A;
                  cnt      <= '0;
                  carry    <= 1'b1;
                  neg_q    <= neg_sel;
                  ovf_pend <= neg_sel && (A == MOST_NEG);
               end
            end
            RUN: begin
               // Operand shifts right one digit per cycle; result digits enter
               // at the top so digit k ends up at bit k*D after N/D shifts.
               opnd  <= opnd >> D;
               res   <= (res >> D) | (N'(r_dig) << (N - D));
               carry <= carry_nxt;
               cnt   <= cnt + 1'b1;
            end
            DONE: begin
`ifdef COMP2_SAT_EN
               C <= ovf_pend ? MAX_POS : res;
`else
               C <= res;
`endif
               ovf  <= ovf_pend;
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_comp2_serial.sv
// tb_comp2_serial: scoreboard bench for comp2_serial (N=8, D=2).
module tb_comp2_serial;

   localparam int N    = 8;
   localparam int D    = 2;
   localparam int NDIG = N / D;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [1:0]   mode;
   logic [N-1:0] A;
   logic         busy;
   logic         done;
   logic [N-1:0] C;
   logic         ovf;

   int           tests = 0;
   int           fails = 0;
   logic [N:0]   exp_q[$];
   logic [N:0]   last_exp;

   always #5 clk = ~clk;

   comp2_serial #(.N(N), .D(D)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .mode  (mode),
      .A     (A),
      .busy  (busy),
      .done  (done),
      .C     (C),
      .ovf   (ovf)
   );

   // Reference: plain integer arithmetic on the whole operand.
   function automatic logic [N:0] model(input logic [1:0] m, input logic [N-1:0] a);
      bit           neg;
      bit           o;
      int           v;
      logic [N-1:0] r;
      v = int'($signed(a));
      case (m)
         2'd0:    neg = 1'b0;
         2'd1:    neg = 1'b1;
         2'd2:    neg = (v < 0);
         default: neg = (v >= 0);
      endcase
      r = neg ? N'(0 - v) : a;
      o = neg && (v == -(1 << (N - 1)));
`ifdef COMP2_SAT_EN
      if (o) r = N'((1 << (N - 1)) - 1);
`endif
      return {o, r};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse consumes one scoreboard entry.
   initial begin
      logic [N:0] e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 32'(done), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("result_C", 32'(C), 32'(e[N-1:0]));
               check("result_ovf", 32'(ovf), 32'(e[N]));
            end
         end
      end
   end

   task automatic run_op(input logic [1:0] m, input logic [N-1:0] a, input bit disturb);
      int busy_cycles;
      int lat;
      bit seen;
      mode  = m;
      A     = a;
      start = 1'b1;
      last_exp = model(m, a);
      exp_q.push_back(last_exp);
      @(posedge clk);
      #1 start = 1'b0;
      busy_cycles = 0;
      lat  = 0;
      seen = 1'b0;
      for (int i = 1; i <= 40 && !seen; i++) begin
         @(negedge clk);
         if (busy) busy_cycles++;
         if (done) begin
            seen = 1'b1;
            lat  = i;
         end
         if (disturb && i == 2) begin
            start = 1'b1;
            A     = 8'h33;
            mode  = 2'd0;
         end
         if (disturb && i == 3) begin
            start = 1'b0;
            A     = ~a;
         end
      end
      start = 1'b0;
      check("done_seen", 32'(seen), 32'd1);
      check("latency", 32'(lat), 32'(NDIG + 2));
      check("busy_cycles", 32'(busy_cycles), 32'(NDIG + 1));
   endtask

   initial begin
      logic [N-1:0] ra;
      logic [1:0]   rm;
      int           sel;
      int           guard;

      rst   = 1'b1;
      start = 1'b0;
      mode  = 2'd0;
      A     = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_C", 32'(C), 32'd0);
      check("reset_ovf", 32'(ovf), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_op(2'd1, 8'h05, 1'b0);
      run_op(2'd2, 8'h9C, 1'b0);
      run_op(2'd3, 8'h64, 1'b0);
      run_op(2'd0, 8'h5A, 1'b0);
      run_op(2'd2, 8'h80, 1'b0);
      run_op(2'd3, 8'h80, 1'b0);
      run_op(2'd1, 8'h80, 1'b0);
      run_op(2'd1, 8'h00, 1'b0);
      run_op(2'd1, 8'hFF, 1'b0);
      run_op(2'd1, 8'h10, 1'b1);

      // Abort mid-RUN: no done may follow and outputs return to reset values.
      @(negedge clk);
      mode  = 2'd1;
      A     = 8'h22;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_C", 32'(C), 32'd0);
      check("abort_ovf", 32'(ovf), 32'd0);
      repeat (NDIG + 4) @(negedge clk);
      check("abort_idle", 32'(busy), 32'd0);

      run_op(2'd1, 8'h22, 1'b0);

      for (int k = 0; k < 40; k++) begin
         rm  = 2'($urandom_range(0, 3));
         sel = int'($urandom_range(0, 7));
         case (sel)
            0:       ra = 8'h80;
            1:       ra = 8'h00;
            2:       ra = 8'hFF;
            3:       ra = 8'h7F;
            default: ra = N'($urandom);
         endcase
         run_op(rm, ra, 1'b0);
      end

      repeat (5) @(negedge clk);
      check("hold_C", 32'(C), 32'(last_exp[N-1:0]));
      check("hold_ovf", 32'(ovf), 32'(last_exp[N]));

      guard = 0;
      while (exp_q.size() != 0 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
